// File: rtl/clock_pkg.sv
// Shared definitions for the BCD time-of-day counter: field layout, field maxima,
// reset value and the packed-BCD time validity check.
package clock_pkg;

  localparam int CC_LSB     = 0;
  localparam int SS_LSB     = 8;
  localparam int MM_LSB     = 16;
  localparam int HH_LSB     = 24;
  localparam int NUM_FIELDS = 4;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;
  localparam logic [7:0] CC_MAX = 8'h99;

  localparam logic [31:0] RESET_TIME = 32'h0000_0000;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [7:0] cc;
  } bcd_time_t;

  // Field index 0 is hundredths, 3 is hours.
  function automatic logic [7:0] field_max(input int idx);
    case (idx)
      0:       return CC_MAX;
      1, 2:    return MS_MAX;
      default: return HH_MAX;
    endcase
  endfunction

  function automatic int field_lsb(input int idx);
    case (idx)
      0:       return CC_LSB;
      1:       return SS_LSB;
      2:       return MM_LSB;
      default: return HH_LSB;
    endcase
  endfunction

  // Once every digit is <= 9, BCD byte ordering matches numeric ordering,
  // so a plain compare against the field maximum is enough.
  function automatic logic bcd_time_valid(input logic [31:0] t);
    bcd_time_t f;
    logic      ok;
    f  = t;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (f.hh > HH_MAX) ok = 1'b0;
    if (f.mm > MS_MAX) ok = 1'b0;
    if (f.ss > MS_MAX) ok = 1'b0;
    if (f.cc > CC_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter wrapping at MAX, with synchronous load and a
// carry-out that is high when an increment wraps the pair back to 00.
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = CC_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      if (value_q == MAX) begin
        value_d = 8'h00;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= RESET_TIME[CC_LSB +: 8];
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && !load && (value_q == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS:CC BCD time-of-day counter driven by a run-gated prescaler.
// Optional alarm compare is compiled in with `define BCD_TIME_ALARM_EN.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load,
  input  logic [31:0] load_time,
  output logic [31:0] time_bcd,
  output logic        tick,
  output logic        day_wrap,
  output logic        load_err
`ifdef BCD_TIME_ALARM_EN
  ,
  input  logic [31:0] alarm_time,
  output logic        alarm_hit
`endif
);

  localparam int DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
  localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  if (TICK_HZ <= 0) begin : g_tick_hz_check
    $error("bcd_time_counter: TICK_HZ must be positive");
  end
  if (DIV < 2) begin : g_div_check
    $error("bcd_time_counter: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, day_wrap_q, load_err_q;
  logic          load_ok, presc_done, advance, load_apply;
  logic [NUM_FIELDS-1:0] inc_chain;
  logic [NUM_FIELDS-1:0] carry_vec;

  assign load_ok    = bcd_time_valid(load_time);
  assign load_apply = load && load_ok;
  assign presc_done = run && (presc_q == PRESC_LAST);
  // Any load, even a rejected one, takes priority over the pending increment.
  assign advance    = presc_done && !load;

  always_comb begin
    presc_d = presc_q;
    if (load) begin
      if (load_ok) presc_d = '0;
    end else if (run) begin
      presc_d = presc_done ? '0 : presc_q + PW'(1);
    end
  end

  assign inc_chain[0] = advance;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      bcd_pair_counter #(
        .MAX(field_max(gi))
      ) u_pair (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc_chain[gi]),
        .load    (load_apply),
        .load_val(load_time[field_lsb(gi) +: 8]),
        .value   (time_bcd[field_lsb(gi) +: 8]),
        .carry   (carry_vec[gi])
      );
      if (gi < NUM_FIELDS - 1) begin : g_chain
        assign inc_chain[gi+1] = carry_vec[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= advance;
      day_wrap_q <= carry_vec[NUM_FIELDS-1];
      load_err_q <= load && !load_ok;
    end
  end

  assign tick     = tick_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

`ifdef BCD_TIME_ALARM_EN
  logic alarm_hit_q;

  // tick_q marks that the current time_bcd came from an increment, so a load
  // landing on the alarm value never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_hit_q <= 1'b0;
    end else begin
      alarm_hit_q <= tick_q && bcd_time_valid(alarm_time) && (time_bcd == alarm_time);
    end
  end

  assign alarm_hit = alarm_hit_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter with DIV = 10.
// Define BCD_TIME_ALARM_EN to include the alarm scenario.
module tb_bcd_time_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_time = 32'h0;
  logic [31:0] time_bcd;
  logic        tick, day_wrap, load_err;
`ifdef BCD_TIME_ALARM_EN
  logic [31:0] alarm_time = 32'hFFFF_FFFF;
  logic        alarm_hit;
`endif

  int checks = 0;
  int errors = 0;

  bcd_time_counter #(
    .CLK_HZ (1000),
    .TICK_HZ(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .load      (load),
    .load_time (load_time),
    .time_bcd  (time_bcd),
    .tick      (tick),
    .day_wrap  (day_wrap),
    .load_err  (load_err)
`ifdef BCD_TIME_ALARM_EN
    ,
    .alarm_time(alarm_time),
    .alarm_hit (alarm_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (time_bcd !== 32'h0) begin errors++; $display("FAIL reset_time got %h want %h", time_bcd, 32'h0); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
    checks++; if (day_wrap !== 1'b0) begin errors++; $display("FAIL reset_day_wrap got %b want 0", day_wrap); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b want 0", load_err); end
    $display("reset: time=%h tick=%b", time_bcd, tick);
    rst = 1'b0;
  endtask

  task automatic test_count();
    int ticks = 0;
    int first = 0;
    run = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (tick === 1'b1) begin
        ticks++;
        if (first == 0) first = i;
      end
    end
    run = 1'b0;
    checks++; if (time_bcd !== 32'h0000_0010) begin errors++; $display("FAIL count_time got %h want %h", time_bcd, 32'h0000_0010); end
    checks++; if (ticks != 10) begin errors++; $display("FAIL count_ticks got %0d want 10", ticks); end
    checks++; if (first != 10) begin errors++; $display("FAIL count_first_tick got cycle %0d want 10", first); end
    $display("count: time=%h ticks=%0d first=%0d", time_bcd, ticks, first);
  endtask

  task automatic test_day_wrap();
    int wraps = 0;
    load = 1'b1; load_time = 32'h2359_5999;
    step();
    load = 1'b0;
    checks++; if (time_bcd !== 32'h2359_5999) begin errors++; $display("FAIL wrap_load got %h want %h", time_bcd, 32'h2359_5999); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL wrap_load_err got %b want 0", load_err); end
    run = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (day_wrap === 1'b1) wraps++;
      if (i == 10) begin
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL wrap_tick got %b want 1", tick); end
        checks++; if (day_wrap !== 1'b1) begin errors++; $display("FAIL wrap_day_wrap got %b want 1", day_wrap); end
        checks++; if (time_bcd !== 32'h0) begin errors++; $display("FAIL wrap_time got %h want %h", time_bcd, 32'h0); end
      end
    end
    run = 1'b0;
    checks++; if (wraps != 1) begin errors++; $display("FAIL wrap_count got %0d want 1", wraps); end
    $display("day_wrap: time=%h wraps=%0d", time_bcd, wraps);
  endtask

  task automatic test_bad_load();
    int errs = 0;
    load = 1'b1; load_time = 32'h2400_0000;
    step();
    if (load_err === 1'b1) errs++;
    checks++; if (time_bcd !== 32'h0) begin errors++; $display("FAIL bad_load1_time got %h want %h", time_bcd, 32'h0); end
    load_time = 32'h1260_0000;
    step();
    if (load_err === 1'b1) errs++;
    checks++; if (time_bcd !== 32'h0) begin errors++; $display("FAIL bad_load2_time got %h want %h", time_bcd, 32'h0); end
    load = 1'b0;
    step();
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL bad_load_err_clear got %b want 0", load_err); end
    checks++; if (errs != 2) begin errors++; $display("FAIL bad_load_pulses got %0d want 2", errs); end
    $display("bad_load: pulses=%0d time=%h", errs, time_bcd);
  endtask

  task automatic test_load_on_tick();
    int next = 0;
    run = 1'b1;
    for (int i = 0; i < 9; i++) step();
    load = 1'b1; load_time = 32'h0102_0304;
    step();
    load = 1'b0;
    checks++; if (time_bcd !== 32'h0102_0304) begin errors++; $display("FAIL lot_time got %h want %h", time_bcd, 32'h0102_0304); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL lot_tick got %b want 0", tick); end
    for (int i = 1; i <= 20 && next == 0; i++) begin
      step();
      if (tick === 1'b1) next = i;
    end
    run = 1'b0;
    checks++; if (next != 10) begin errors++; $display("FAIL lot_next_tick got cycle %0d want 10", next); end
    checks++; if (time_bcd !== 32'h0102_0305) begin errors++; $display("FAIL lot_after got %h want %h", time_bcd, 32'h0102_0305); end
    $display("load_on_tick: time=%h next_tick=%0d", time_bcd, next);
  endtask

  task automatic test_run_pause();
    int cyc = 0;
    int first = 0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); cyc++; end
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin step(); cyc++; if (tick === 1'b1 && first == 0) first = cyc; end
    run = 1'b1;
    for (int i = 0; i < 20 && first == 0; i++) begin
      step(); cyc++;
      if (tick === 1'b1) first = cyc;
    end
    checks++; if (first != 17) begin errors++; $display("FAIL pause_tick got cycle %0d want 17", first); end
    checks++; if (time_bcd !== 32'h0102_0306) begin errors++; $display("FAIL pause_time got %h want %h", time_bcd, 32'h0102_0306); end
    $display("run_pause: tick_cycle=%0d time=%h", first, time_bcd);
  endtask

  task automatic test_async_reset();
    int seen = 0;
    int first = 0;
    run = 1'b1;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      if (tick === 1'b1) seen = 1;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL areset_pre_tick got %0d want 1", seen); end
    #2 rst = 1'b1;
    #1;
    checks++; if (time_bcd !== 32'h0) begin errors++; $display("FAIL areset_time got %h want %h", time_bcd, 32'h0); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL areset_tick got %b want 0", tick); end
    checks++; if (day_wrap !== 1'b0) begin errors++; $display("FAIL areset_day_wrap got %b want 0", day_wrap); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL areset_load_err got %b want 0", load_err); end
    step();
    rst = 1'b0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      step();
      if (tick === 1'b1) first = i;
    end
    run = 1'b0;
    checks++; if (first != 10) begin errors++; $display("FAIL areset_first_tick got cycle %0d want 10", first); end
    $display("async_reset: first_tick=%0d time=%h", first, time_bcd);
  endtask

`ifdef BCD_TIME_ALARM_EN
  task automatic test_alarm();
    int hits = 0;
    int hit_cyc = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    alarm_time = 32'h0000_0105;
    run = 1'b1;
    for (int i = 1; i <= 1070; i++) begin
      step();
      if (alarm_hit === 1'b1) begin hits++; if (hit_cyc == 0) hit_cyc = i; end
    end
    run = 1'b0;
    checks++; if (hits != 1) begin errors++; $display("FAIL alarm_hits got %0d want 1", hits); end
    checks++; if (hit_cyc != 1051) begin errors++; $display("FAIL alarm_cycle got %0d want 1051", hit_cyc); end
    load = 1'b1; load_time = 32'h0000_0105;
    step();
    load = 1'b0;
    hits = 0;
    for (int i = 0; i < 5; i++) begin step(); if (alarm_hit === 1'b1) hits++; end
    checks++; if (hits != 0) begin errors++; $display("FAIL alarm_on_load got %0d want 0", hits); end
    $display("alarm: hit_cycle=%0d", hit_cyc);
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_day_wrap();
    test_bad_load();
    test_load_on_tick();
    test_run_pause();
    test_async_reset();
`ifdef BCD_TIME_ALARM_EN
    test_alarm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
